// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling from a private bit timer,
// one-cycle rx_valid / frame_err pulses and break (held-low line) suppression.
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int HALF  = CLOCKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state, state_n;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, idx_n;
  logic [7:0]       shift, shift_n, data_n;
  logic             valid_n, ferr_n;

  // Flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= idx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = bit_idx;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;  // high at mid-start: glitch, drop it
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 idx_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BRK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      BRK: begin
        // Hold here until the line recovers so a break is not decoded as 0x00 frames.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks/bit: constant vector table, directed corner sequences,
// and random frames checked against a sample-time model of the receiver.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int STOP_OFF = 2 + HALF + 9 * CPB;  // event edge relative to E0

  logic       clk = 1'b0;
  logic       reset, rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
    logic       v;
    logic       f;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    int         p10;       // sender bit period in tenths of a cycle
    logic [7:0] exp_data;
    int         exp_off;   // rx_valid edge relative to E0
  } vec_t;

  int   cyc = 0;
  int   busy_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];
  logic [7:0] last_good;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid || frame_err) got_q.push_back('{cyc, rx_data, rx_valid, frame_err});
    if (busy) busy_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bnd(input int j, input int p10);
    return (j * p10 + 5) / 10;
  endfunction

  // Sender line level at offset x cycles after E0; lv = {stop, data, start}.
  function automatic logic level_at(input int x, input logic [9:0] lv, input logic after,
                                    input int p10);
    for (int j = 0; j < 10; j++)
      if (x >= bnd(j, p10) && x < bnd(j + 1, p10)) return lv[j];
    return after;
  endfunction

  // Receiver samples rx (as captured by flop 1) at E0+HALF+(k+1)*CPB; stop at k=8.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic after,
                             input int p10, input int e0);
    logic [9:0] lv;
    logic [7:0] b;
    logic       sb;
    lv = {stop, d, 1'b0};
    for (int k = 0; k < 8; k++) b[k] = level_at(HALF + (k + 1) * CPB, lv, after, p10);
    sb = level_at(HALF + 9 * CPB, lv, after, p10);
    if (sb) begin
      exp_q.push_back('{e0 + STOP_OFF, b, 1'b1, 1'b0});
      last_good = b;
    end else begin
      exp_q.push_back('{e0 + STOP_OFF, last_good, 1'b0, 1'b1});
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop, input int p10,
                             output int e0);
    logic [9:0] lv;
    lv = {stop, d, 1'b0};
    e0 = cyc + 1;
    for (int j = 0; j < 10; j++) begin
      rx = lv[j];
      tick(bnd(j + 1, p10) - bnd(j, p10));
    end
  endtask

  task automatic check_events(input string name);
    ev_t g, e;
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_edge"},  g.edge_n, e.edge_n);
      check({name, "_data"},  g.data,   e.data);
      check({name, "_valid"}, g.v,      e.v);
      check({name, "_ferr"},  g.f,      e.f);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[6];
    int   e0, e0b;
    logic [7:0] d;
    logic stop;
    int   p10;

    tbl[0] = '{8'hA5, 160, 8'hA5, 154};
    tbl[1] = '{8'h00, 160, 8'h00, 154};
    tbl[2] = '{8'hFF, 160, 8'hFF, 154};
    tbl[3] = '{8'h69, 154, 8'h69, 154};  // 6 cycles short over 10 bits
    tbl[4] = '{8'h69, 166, 8'h69, 154};  // 6 cycles long over 10 bits
    tbl[5] = '{8'h5A, 160, 8'h5A, 154};

    rx = 1'b1;
    reset = 1'b1;
    tick(3);
    check("reset_data",  rx_data,   8'h00);
    check("reset_valid", rx_valid,  1'b0);
    check("reset_ferr",  frame_err, 1'b0);
    check("reset_busy",  busy,      1'b0);
    reset = 1'b0;
    tick(5);
    got_q.delete();
    last_good = 8'h00;

    foreach (tbl[i]) begin
      drive_frame(tbl[i].d, 1'b1, tbl[i].p10, e0);
      tick(12);
      exp_q.push_back('{e0 + tbl[i].exp_off, tbl[i].exp_data, 1'b1, 1'b0});
      check_events($sformatf("vec%0d", i));
      last_good = tbl[i].exp_data;
    end

    // Back-to-back: second start bit directly after first stop bit.
    drive_frame(8'h00, 1'b1, 160, e0);
    drive_frame(8'hFF, 1'b1, 160, e0b);
    tick(12);
    exp_q.push_back('{e0 + 154, 8'h00, 1'b1, 1'b0});
    exp_q.push_back('{e0 + 314, 8'hFF, 1'b1, 1'b0});
    check_events("b2b");
    last_good = 8'hFF;

    // Glitch: 4-cycle low is abandoned after HALF cycles of busy.
    busy_cnt = 0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    check("glitch_busy_cycles", busy_cnt, HALF);
    check_events("glitch");
    check("glitch_data", rx_data, 8'hFF);

    // Framing error followed by a 100-cycle break, then a clean frame.
    drive_frame(8'h3C, 1'b0, 160, e0);
    model_frame(8'h3C, 1'b0, 1'b0, 160, e0);
    tick(100);
    check("break_busy", busy, 1'b1);
    check("break_data", rx_data, 8'hFF);
    rx = 1'b1;
    tick(6);
    check("break_exit_busy", busy, 1'b0);
    tick(20);
    drive_frame(8'h81, 1'b1, 160, e0b);
    model_frame(8'h81, 1'b1, 1'b1, 160, e0b);
    tick(12);
    check_events("ferr_break");

    // Reset in the middle of data bit 3 of 0x5A; sender aborts the frame.
    d = 8'h5A;
    rx = 1'b0;
    tick(CPB);
    for (int k = 0; k < 3; k++) begin
      rx = d[k];
      tick(CPB);
    end
    rx = d[3];
    tick(HALF);
    reset = 1'b1;
    tick(1);
    check("midrst_data",  rx_data,   8'h00);
    check("midrst_valid", rx_valid,  1'b0);
    check("midrst_ferr",  frame_err, 1'b0);
    check("midrst_busy",  busy,      1'b0);
    reset = 1'b0;
    rx = 1'b1;
    tick(40);
    check_events("midrst_quiet");
    last_good = 8'h00;
    drive_frame(8'h5A, 1'b1, 160, e0);
    model_frame(8'h5A, 1'b1, 1'b1, 160, e0);
    tick(12);
    check_events("midrst_next");

    // Random frames, rates inside the tolerance window, occasional bad stop bit.
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      p10  = int'($urandom_range(154, 166));
      stop = ($urandom_range(0, 3) != 0);
      drive_frame(d, stop, p10, e0);
      model_frame(d, stop, stop, p10, e0);
      if (!stop) begin
        tick(int'($urandom_range(0, 30)));
        rx = 1'b1;
      end
      tick(int'($urandom_range(8, 30)));
      check_events($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
